// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I main control FSM for a shared-memory datapath.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB, stalls on the
// memory ready handshake with a bounded wait, counts retired instructions and
// keeps sticky fault flags.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   op              opcode from the instruction register (IR[6:0])
//   mem_ready       memory accepted write / read data valid this cycle
//   pc_update       unconditional PC write strobe
//   branch          conditional PC write (datapath ANDs with Zero)
//   adr_src         memory address select: 0 PC, 1 ALUOut
//   mem_write       memory write request
//   ir_write        latch IR and OldPC
//   result_src      00 ALUOut, 01 mem data, 10 ALUResult
//   alu_src_a       00 PC, 01 OldPC, 10 rs1, 11 zero
//   alu_src_b       00 rs2, 01 imm, 10 const 4
//   alu_op          00 add, 01 sub/compare, 10 funct3/7
//   imm_src         000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
//   reg_write       register file write
//   instret         retired instruction count (wraps)
//   mem_fault       sticky: memory wait timeout
//   illegal         sticky: unsupported opcode seen
//
// Build option: define ILLEGAL_TRAP_EN to halt on an unsupported opcode;
// otherwise such an opcode is flagged and retired as a NOP.
module mc_controller #(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op,
   input  logic             mem_ready,
   output logic             pc_update,
   output logic             branch,
   output logic             adr_src,
   output logic             mem_write,
   output logic             ir_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [2:0]       imm_src,
   output logic             reg_write,
   output logic [CNT_W-1:0] instret,
   output logic             mem_fault,
   output logic             illegal
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Timeout fires when the counter already holds WAIT_MAX-1 and ready is
   // still low, i.e. on the WAIT_MAX-th consecutive waiting cycle.
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXER, S_EXEI, S_ALUWB, S_BEQ, S_JAL, S_JALR1, S_JALR2,
      S_LUI, S_AUIPC, S_HALT
   } state_t;

   state_t     state, nxt;
   logic [7:0] wait_cnt;
   logic       in_wait, timeout, ill_set, pc_upd_q;

   assign in_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
   assign timeout = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);

   always_comb begin
      nxt     = state;
      ill_set = 1'b0;
      case (state)
         S_FETCH:    if (mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_R:              nxt = S_EXER;
               OP_IMM:            nxt = S_EXEI;
               OP_BRANCH:         nxt = S_BEQ;
               OP_JAL:            nxt = S_JAL;
               OP_JALR:           nxt = S_JALR1;
               OP_LUI:            nxt = S_LUI;
               OP_AUIPC:          nxt = S_AUIPC;
               default: begin
                  ill_set = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                  nxt = S_HALT;
`else
                  nxt = S_FETCH;
`endif
               end
            endcase
         end
         S_MEMADR:   nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
         S_MEMWB:    nxt = S_FETCH;
         S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
         S_EXER, S_EXEI, S_JAL, S_JALR2, S_LUI, S_AUIPC: nxt = S_ALUWB;
         S_ALUWB, S_BEQ: nxt = S_FETCH;
         S_JALR1:    nxt = S_JALR2;
         default:    nxt = S_HALT;
      endcase
      if (timeout) nxt = S_HALT;
   end

   // State, counters, flags and Moore outputs (decoded from the next state so
   // they are valid as soon as the state register updates).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FETCH;
         wait_cnt   <= 8'd0;
         instret    <= '0;
         mem_fault  <= 1'b0;
         illegal    <= 1'b0;
         pc_upd_q   <= 1'b0;
         branch     <= 1'b0;
         adr_src    <= 1'b0;
         mem_write  <= 1'b0;
         reg_write  <= 1'b0;
         result_src <= 2'b10;
         alu_src_a  <= 2'b00;
         alu_src_b  <= 2'b10;
         alu_op     <= 2'b00;
      end else begin
         state <= nxt;
         // Leaving a wait state (ready or timeout) always clears the counter,
         // so every entry into a wait state starts from zero.
         if (in_wait && !mem_ready && nxt == state) wait_cnt <= wait_cnt + 8'd1;
         else                                        wait_cnt <= 8'd0;
         if (timeout) mem_fault <= 1'b1;
         if (ill_set) illegal   <= 1'b1;
         if (nxt == S_FETCH && state != S_FETCH && state != S_HALT)
            instret <= instret + CNT_W'(1);

         pc_upd_q   <= 1'b0;
         branch     <= 1'b0;
         adr_src    <= 1'b0;
         mem_write  <= 1'b0;
         reg_write  <= 1'b0;
         result_src <= 2'b00;
         alu_src_a  <= 2'b00;
         alu_src_b  <= 2'b00;
         alu_op     <= 2'b00;
         case (nxt)
            S_FETCH:    begin result_src <= 2'b10; alu_src_b <= 2'b10; end
            S_DECODE:   begin alu_src_a <= 2'b01; alu_src_b <= 2'b01; end
            S_MEMADR:   begin alu_src_a <= 2'b10; alu_src_b <= 2'b01; end
            S_MEMREAD:  adr_src <= 1'b1;
            S_MEMWB:    begin result_src <= 2'b01; reg_write <= 1'b1; end
            S_MEMWRITE: begin adr_src <= 1'b1; mem_write <= 1'b1; end
            S_EXER:     begin alu_src_a <= 2'b10; alu_op <= 2'b10; end
            S_EXEI:     begin alu_src_a <= 2'b10; alu_src_b <= 2'b01; alu_op <= 2'b10; end
            S_ALUWB:    reg_write <= 1'b1;
            S_BEQ:      begin alu_src_a <= 2'b10; alu_op <= 2'b01; branch <= 1'b1; end
            S_JAL, S_JALR2: begin alu_src_a <= 2'b01; alu_src_b <= 2'b10; pc_upd_q <= 1'b1; end
            S_JALR1:    begin alu_src_a <= 2'b10; alu_src_b <= 2'b01; end
            S_LUI:      begin alu_src_a <= 2'b11; alu_src_b <= 2'b01; end
            S_AUIPC:    begin alu_src_a <= 2'b01; alu_src_b <= 2'b01; end
            default: ;
         endcase
      end
   end

   // FETCH strobes follow mem_ready directly; rst masks them so no strobe
   // leaks out while reset is held.
   assign ir_write  = (state == S_FETCH) && mem_ready && !rst;
   assign pc_update = pc_upd_q || ir_write;

   always_comb begin
      case (op)
         OP_STORE:         imm_src = 3'b001;
         OP_BRANCH:        imm_src = 3'b010;
         OP_JAL:           imm_src = 3'b011;
         OP_LUI, OP_AUIPC: imm_src = 3'b100;
         default:          imm_src = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: per-cycle vector table driven through a
// scoreboard queue, plus hand sequences for reset, timeout and illegal opcodes.
module tb_mc_controller;

   localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011,
                          OPI = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                          JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111,
                          BAD = 7'b1111111;

   logic        clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
   logic [6:0]  op = OPR;
   logic        pc_update, branch, adr_src, mem_write, ir_write, reg_write;
   logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
   logic [2:0]  imm_src;
   logic [31:0] instret;
   logic        mem_fault, illegal;

   mc_controller #(.WAIT_MAX(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .pc_update(pc_update), .branch(branch), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .imm_src(imm_src), .reg_write(reg_write), .instret(instret),
      .mem_fault(mem_fault), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // {pc_update, branch, adr_src, mem_write, ir_write, result_src, a, b, alu_op, imm_src, reg_write}
   logic [16:0] ctl;
   assign ctl = {pc_update, branch, adr_src, mem_write, ir_write, result_src,
                 alu_src_a, alu_src_b, alu_op, imm_src, reg_write};

   typedef struct {
      logic [6:0]  op;
      logic        rdy;
      logic [16:0] ctl;
      int unsigned inst;
   } vec_t;

   vec_t        tbl[$];
   vec_t        sb[$];
   int          errors = 0, checks = 0;
   logic [6:0]  op_c;
   logic [2:0]  imm_c;
   int unsigned inst_c = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic put(input logic r, input logic pcu, input logic br, input logic adr,
                      input logic mw, input logic irw, input logic [1:0] res,
                      input logic [1:0] a, input logic [1:0] b, input logic [1:0] aop,
                      input logic rw);
      vec_t v;
      v.op   = op_c;
      v.rdy  = r;
      v.ctl  = {pcu, br, adr, mw, irw, res, a, b, aop, imm_c, rw};
      v.inst = inst_c;
      tbl.push_back(v);
   endtask

   task automatic ins(input logic [6:0] o, input logic [2:0] im);
      op_c  = o;
      imm_c = im;
   endtask

   task automatic fetch(input logic r);
      put(r, r, 0, 0, 0, r, 2'b10, 2'b00, 2'b10, 2'b00, 0);
   endtask

   task automatic decode(input logic r);
      put(r, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
   endtask

   task automatic aluwb();
      put(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t e;
      // ---------------- vector table ----------------
      // R-type; mem_ready high in DECODE must be ignored
      ins(OPR, 3'b000);   fetch(1); decode(1);
      put(0, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0);            // EXER
      aluwb(); inst_c++;
      // LW, ready delayed 3 cycles in MEMREAD (arrives on the last allowed cycle)
      ins(LOAD, 3'b000);  fetch(1); decode(0);
      put(0, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0);            // MEMADR
      repeat (3) put(0, 0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0); // MEMREAD wait
      put(1, 0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0);            // MEMREAD ready
      put(0, 0,0,0,0,0, 2'b01, 2'b00, 2'b00, 2'b00, 1);            // MEMWB
      inst_c++;
      // JALR
      ins(JALR, 3'b000);  fetch(1); decode(0);
      put(0, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0);            // JALR1
      put(0, 1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 0);            // JALR2
      aluwb(); inst_c++;
      // SW, one stall cycle in MEMWRITE
      ins(STORE, 3'b001); fetch(1); decode(0);
      put(0, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0);            // MEMADR
      put(0, 0,0,1,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0);            // MEMWRITE wait
      put(1, 0,0,1,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0);            // MEMWRITE ready
      inst_c++;
      // BEQ
      ins(BR, 3'b010);    fetch(1); decode(0);
      put(0, 0,1,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 0);            // BEQ
      inst_c++;
      // JAL
      ins(JAL, 3'b011);   fetch(1); decode(0);
      put(0, 1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 0);            // JAL
      aluwb(); inst_c++;
      // LUI, fetch ready arrives on the 4th waiting cycle (no timeout)
      ins(LUI, 3'b100);   fetch(0); fetch(0); fetch(0); fetch(1); decode(0);
      put(0, 0,0,0,0,0, 2'b00, 2'b11, 2'b01, 2'b00, 0);            // LUI
      aluwb(); inst_c++;
      // AUIPC
      ins(AUIPC, 3'b100); fetch(1); decode(0);
      put(0, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0);            // AUIPC
      aluwb(); inst_c++;
      // OP_IMM
      ins(OPI, 3'b000);   fetch(1); decode(0);
      put(0, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, 0);            // EXEI
      aluwb(); inst_c++;

      // ---------------- reset state ----------------
      @(negedge clk);
      chk("rst_strobes", {27'd0, pc_update, branch, mem_write, ir_write, reg_write}, 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_flags", {30'd0, mem_fault, illegal}, 32'd0);
      tick(); rst = 1'b0;

      // ---------------- table through scoreboard ----------------
      foreach (tbl[i]) begin
         op = tbl[i].op;
         mem_ready = tbl[i].rdy;
         sb.push_back(tbl[i]);
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("ctl[%0d]", i), {15'd0, ctl}, {15'd0, e.ctl});
         chk($sformatf("instret[%0d]", i), instret, 32'(e.inst));
         chk($sformatf("flags[%0d]", i), {30'd0, mem_fault, illegal}, 32'd0);
         tick();
      end

      // ---------------- unsupported opcode ----------------
      op = BAD; mem_ready = 1'b1;
      @(negedge clk); chk("ill_fetch_irw", {31'd0, ir_write}, 32'd1);
      tick();
      @(negedge clk); chk("ill_decode_ctl", {15'd0, ctl}, {15'd0, 17'b0_0_0_0_0_00_01_01_00_000_0});
      tick();
      @(negedge clk);
      chk("ill_flag", {31'd0, illegal}, 32'd1);
`ifdef ILLEGAL_TRAP_EN
      chk("ill_halt_irw", {31'd0, ir_write}, 32'd0);
      chk("ill_instret", instret, 32'(inst_c));
`else
      chk("ill_nop_irw", {31'd0, ir_write}, 32'd1);
      chk("ill_instret", instret, 32'(inst_c + 1));
`endif

      // ---------------- async reset clears everything ----------------
      tick(); rst = 1'b1; #1;
      chk("rst2_illegal", {31'd0, illegal}, 32'd0);
      chk("rst2_instret", instret, 32'd0);
      tick(); rst = 1'b0; op = OPR; mem_ready = 1'b0;

      // ---------------- fetch timeout (WAIT_MAX=4) ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("to_pre_fault", {31'd0, mem_fault}, 32'd0);
      @(posedge clk); #1 mem_ready = 1'b1;
      @(negedge clk);
      chk("to_fault", {31'd0, mem_fault}, 32'd1);
      chk("to_halt_strobes", {27'd0, pc_update, branch, mem_write, ir_write, reg_write}, 32'd0);
      tick();
      @(negedge clk);
      chk("to_halt_stays", {30'd0, ir_write, pc_update}, 32'd0);
      chk("to_instret", instret, 32'd0);

      // ---------------- reset in the middle of MEMWRITE ----------------
      tick(); rst = 1'b1;
      tick(); rst = 1'b0; op = STORE; mem_ready = 1'b1;
      tick(); mem_ready = 1'b0;       // DECODE
      tick();                          // MEMADR
      tick();                          // MEMWRITE
      @(negedge clk);
      chk("mw_before_rst", {31'd0, mem_write}, 32'd1);
      #2 rst = 1'b1;
      #1 chk("mw_drop_on_rst", {31'd0, mem_write}, 32'd0);
      chk("mw_rst_fault", {31'd0, mem_fault}, 32'd0);
      tick(); rst = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      chk("mw_after_fetch", {15'd0, ctl}, {15'd0, 17'b1_0_0_0_1_10_00_10_00_001_0});
      chk("mw_after_instret", instret, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
